// File: rtl/stream_source.sv
// Programmable arithmetic sample generator (base, base+step, ...) with optional idle gaps.
// Define STREAM_SOURCE_READY_EN to add an in_ready backpressure input.
module stream_source #(
    parameter int data_width = 16,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
`ifdef STREAM_SOURCE_READY_EN
    input  logic                  in_ready,
`endif
    input  logic [cnt_width-1:0]  len,
    input  logic [data_width-1:0] base,
    input  logic [data_width-1:0] step,
    input  logic [cnt_width-1:0]  gap,
    output logic [data_width-1:0] x,
    output logic                  in_valid,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state_reg,   state_next;
    logic [cnt_width-1:0]  count_reg,   count_next;
    logic [cnt_width-1:0]  len_reg,     len_next;
    logic [cnt_width-1:0]  gap_reg,     gap_next;
    logic [cnt_width-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [data_width-1:0] step_reg,    step_next;
    logic [data_width-1:0] x_reg,       x_next;
    logic                  in_valid_reg, busy_reg, done_reg;
    logic [cnt_width-1:0]  count_inc;
    logic                  xfer;

`ifdef STREAM_SOURCE_READY_EN
    assign xfer = in_ready;
`else
    assign xfer = 1'b1;
`endif

    assign count_inc = count_reg + 1'b1;

    // x_reg always holds the sample currently presented; it only advances
    // when the next sample is actually put on the bus, so it holds through GAP.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        len_next     = len_reg;
        gap_next     = gap_reg;
        gap_cnt_next = gap_cnt_reg;
        step_next    = step_reg;
        x_next       = x_reg;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    len_next   = len;
                    gap_next   = gap;
                    step_next  = step;
                    x_next     = base;
                    count_next = '0;
                    state_next = (len == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    count_next = count_inc;
                    if (count_inc == len_reg) begin
                        state_next = DONE;
                    end else if (gap_reg == '0) begin
                        x_next = x_reg + step_reg;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = gap_reg;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_cnt_reg == cnt_width'(1)) begin
                    state_next = SEND;
                    x_next     = x_reg + step_reg;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // alongside it and never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            len_reg      <= '0;
            gap_reg      <= '0;
            gap_cnt_reg  <= '0;
            step_reg     <= '0;
            x_reg        <= '0;
            in_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            len_reg      <= len_next;
            gap_reg      <= gap_next;
            gap_cnt_reg  <= gap_cnt_next;
            step_reg     <= step_next;
            x_reg        <= x_next;
            in_valid_reg <= (state_next == SEND);
            busy_reg     <= (state_next == SEND) || (state_next == GAP);
            done_reg     <= (state_next == DONE);
        end
    end

    assign x        = x_reg;
    assign in_valid = in_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign state    = state_reg;

endmodule
